// File: rtl/mpa_sequencer.sv
// Multi-precision ALU sequencer: walks byte 0..L-1 through an external 8-bit ALU,
// chaining carry/borrow, writes each result byte and reports the final carry.
module mpa_sequencer #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [ADDR_W:0]   len,
    input  logic              cin,
    output logic [ADDR_W-1:0] idx,
    input  logic [7:0]        a_data,
    input  logic [7:0]        b_data,
    output logic [3:0]        alu_op,
    output logic              alu_ci,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    input  logic [7:0]        alu_out,
    input  logic              alu_cy,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [7:0]        res_data,
    output logic              cy_ce,
    output logic              cy_flag,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0]      OP_ADD  = 4'b0000;
    localparam logic [3:0]      OP_SUB  = 4'b0001;
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [3:0]        op_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              carry_q;
    logic              busy_q;
    logic              done_q;
    logic              cy_ce_q;
    logic              cy_flag_q;

    logic [ADDR_W:0]   eff_len;
    logic              start_carry;
    logic              run;
    logic              last;
    logic [8:0]        b_plus_ci;
    logic              borrow;
    logic              carry_d;

    always_comb begin
        eff_len     = (len > MAX_LEN) ? MAX_LEN : len;
        start_carry = ((op == OP_ADD) || (op == OP_SUB)) ? cin : 1'b0;
        run         = (state_q == S_RUN);
        last        = ({1'b0, cnt_q} == (len_q - LEN_ONE));
        // Borrow compares in 9 bits so b=0xFF with borrow-in does not wrap.
        b_plus_ci   = {1'b0, b_data} + {8'b0, carry_q};
        borrow      = ({1'b0, a_data} < b_plus_ci);
        case (op_q)
            OP_ADD:  carry_d = alu_cy;
            OP_SUB:  carry_d = borrow;
            default: carry_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cy_ce_q   <= 1'b0;
            cy_flag_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            cy_ce_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        len_q   <= eff_len;
                        cnt_q   <= '0;
                        carry_q <= start_carry;
                        busy_q  <= 1'b1;
                        if (eff_len != '0) begin
                            state_q <= S_RUN;
                        end else begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            cy_ce_q   <= 1'b1;
                            cy_flag_q <= start_carry;
                        end
                    end
                end
                S_RUN: begin
                    cnt_q   <= cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    carry_q <= carry_d;
                    if (last) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        cy_ce_q   <= 1'b1;
                        cy_flag_q <= carry_d;
                    end
                end
                S_DONE: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    cy_flag_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath outputs pass through combinationally in RUN and are held at zero elsewhere.
    always_comb begin
        idx      = run ? cnt_q   : '0;
        alu_a    = run ? a_data  : '0;
        alu_b    = run ? b_data  : '0;
        alu_op   = run ? op_q    : '0;
        alu_ci   = run ? carry_q : 1'b0;
        res_we   = run;
        res_addr = run ? cnt_q   : '0;
        res_data = run ? alu_out : '0;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign cy_ce   = cy_ce_q;
    assign cy_flag = cy_flag_q;

endmodule

// File: tb/tb_mpa_sequencer.sv
// Scoreboard bench for mpa_sequencer: expected writes and completion pushed at start,
// popped and compared as the DUT writes bytes and pulses done.
module tb_mpa_sequencer;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    op = '0;
    logic [AW:0]   len = '0;
    logic          cin = 1'b0;
    logic [AW-1:0] idx;
    logic [7:0]    a_data, b_data;
    logic [3:0]    alu_op;
    logic          alu_ci;
    logic [7:0]    alu_a, alu_b, alu_out;
    logic          alu_cy;
    logic          res_we;
    logic [AW-1:0] res_addr;
    logic [7:0]    res_data;
    logic          cy_ce, cy_flag, busy, done;

    logic [7:0] amem [8];
    logic [7:0] bmem [8];
    logic [8:0] alu_sum;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {int addr; int data; bit chk_ci;} wr_t;
    typedef struct {int scyc; int lat; int cf;} dn_t;
    wr_t wq[$];
    dn_t dq[$];

    mpa_sequencer #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .len(len), .cin(cin),
        .idx(idx), .a_data(a_data), .b_data(b_data),
        .alu_op(alu_op), .alu_ci(alu_ci), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_cy(alu_cy),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
        .cy_ce(cy_ce), .cy_flag(cy_flag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    assign a_data = amem[idx];
    assign b_data = bmem[idx];

    // External 8-bit ALU
    always_comb begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_ci};
        alu_cy  = 1'b0;
        case (alu_op)
            4'b0000: begin alu_out = alu_sum[7:0]; alu_cy = alu_sum[8]; end
            4'b0001: alu_out = alu_a - alu_b - {7'b0, alu_ci};
            4'b0010: alu_out = alu_a & alu_b;
            4'b0011: alu_out = alu_a | alu_b;
            4'b0100: alu_out = alu_a ^ alu_b;
            4'b0101: alu_out = ~alu_a;
            default: alu_out = alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: pop expectations as the DUT produces writes and completions
    initial begin
        wr_t w;
        dn_t d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("cy_ce_vs_done", 32'(cy_ce), 32'(done));
                if (res_we) begin
                    check("wr_expected", 32'(wq.size() > 0), 1);
                    check("busy_in_run", 32'(busy), 1);
                    if (wq.size() > 0) begin
                        w = wq.pop_front();
                        check("wr_addr", 32'(res_addr), w.addr);
                        check("wr_data", 32'(res_data), w.data);
                        if (w.chk_ci) check("alu_ci_logic", 32'(alu_ci), 0);
                    end
                end
                if (done) begin
                    check("done_expected", 32'(dq.size() > 0), 1);
                    if (dq.size() > 0) begin
                        d = dq.pop_front();
                        check("done_latency", cyc - d.scyc, d.lat);
                        check("cy_flag", 32'(cy_flag), d.cf);
                    end
                end
            end
        end
    end

    task automatic fill(input logic [63:0] a, input logic [63:0] b);
        for (int i = 0; i < 8; i++) begin
            amem[i] = a[8*i +: 8];
            bmem[i] = b[8*i +: 8];
        end
    endtask

    // Reference: whole-operand arithmetic, independent of byte-serial chaining
    task automatic push_expect(input logic [3:0] o, input int n, input logic ci, input int nwr);
        logic [63:0] av, bv, r;
        logic [64:0] s;
        int cf;
        av = '0;
        bv = '0;
        for (int i = 0; i < n; i++) begin
            av[8*i +: 8] = amem[i];
            bv[8*i +: 8] = bmem[i];
        end
        s  = '0;
        cf = 0;
        case (o)
            4'b0000: begin
                s  = {1'b0, av} + {1'b0, bv} + 65'(ci);
                r  = s[63:0];
                cf = (n == 0) ? int'(ci) : int'(s[8*n]);
            end
            4'b0001: begin
                r  = av - bv - 64'(ci);
                cf = (n == 0) ? int'(ci) : int'({1'b0, av} < ({1'b0, bv} + 65'(ci)));
            end
            4'b0010: r = av & bv;
            4'b0011: r = av | bv;
            4'b0100: r = av ^ bv;
            4'b0101: r = ~av;
            default: r = bv;
        endcase
        for (int i = 0; i < nwr; i++)
            wq.push_back('{i, int'(r[8*i +: 8]), (o != 4'b0000) && (o != 4'b0001)});
        dq.push_back('{cyc, n + 1, cf});
    endtask

    // Issue one operation; optionally pulse start again 'poke' cycles into it
    task automatic run_op(input logic [3:0] o, input int l, input logic ci, input int poke);
        int  n;
        bit  seen;
        n = (l > 8) ? 8 : l;
        @(negedge clk);
        push_expect(o, n, ci, n);
        op    = o;
        len   = (AW+1)'(l);
        cin   = ci;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 4'($urandom);
        len   = (AW+1)'($urandom);
        cin   = 1'($urandom);
        seen  = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (done) seen = 1'b1;
            else begin
                start = (poke != 0) && (k == poke);
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!seen) check("timeout", 32'(done), 1);
        check("wq_drained", wq.size(), 0);
    endtask

    initial begin
        bit hit;
        fill(64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A);
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_res_we", 32'(res_we), 0);
        check("rst_cy_ce", 32'(cy_ce), 0);
        check("rst_cy_flag", 32'(cy_flag), 0);
        check("rst_idx", 32'(idx), 0);
        check("rst_alu_a", 32'(alu_a), 0);
        check("rst_alu_op", 32'(alu_op), 0);
        @(negedge clk);
        rst_n = 1'b1;

        fill(64'h00FF, 64'h0001);             run_op(4'h0, 2, 1'b0, 0);
        fill(64'hFF, 64'h01);                 run_op(4'h0, 1, 1'b0, 0);
        fill(64'h0100, 64'h0001);             run_op(4'h1, 2, 1'b0, 0);
        fill(64'h00, 64'h01);                 run_op(4'h1, 1, 1'b0, 0);
        fill(64'hF0F0_3C3C_FF00_1234, 64'h0FF0_FFFF_F0F0_00FF);
        run_op(4'h2, 8, 1'b1, 0);
        run_op(4'h2, 15, 1'b1, 0);
        fill(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001);
        run_op(4'h0, 4, 1'b0, 2);
        run_op(4'h0, 0, 1'b1, 0);
        run_op(4'h1, 0, 1'b1, 0);
        run_op(4'h2, 0, 1'b1, 0);
        for (int t = 0; t < 10; t++) begin
            fill({$urandom, $urandom}, {$urandom, $urandom});
            run_op(4'($urandom_range(0, 15)), $urandom_range(1, 9), 1'($urandom), 0);
        end
        fill(64'hFFFF_FFFF_FFFF_FFFF, 64'h0);  run_op(4'h0, 8, 1'b1, 0);
        fill(64'h0, 64'h0);                    run_op(4'h1, 8, 1'b1, 0);

        // Abort mid-operation: only the first two bytes may be written
        fill(64'h1122_3344, 64'h0101_0101);
        @(negedge clk);
        push_expect(4'h0, 4, 1'b0, 2);
        op = 4'h0; len = 4'd4; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            if (res_we && res_addr == 3'd1) hit = 1'b1;
            else @(negedge clk);
        end
        check("abort_reached_byte1", 32'(hit), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_res_we", 32'(res_we), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_idx", 32'(idx), 0);
        check("abort_res_data", 32'(res_data), 0);
        check("abort_alu_ci", 32'(alu_ci), 0);
        check("abort_wq", wq.size(), 0);
        dq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_abort_idle", 32'(busy), 0);
        fill(64'h0000_00FF_FFFF, 64'h0000_0000_0001);
        run_op(4'h0, 4, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
